// File: rtl/noc_credit_tx.sv
// -----------------------------------------------------------------------------
// noc_credit_tx
// Upstream end of a credit-based flit link. Flits from a local valid/ready
// source are queued in a small FIFO and launched into a router input port
// only while downstream credits remain, so the router's input buffer
// (FLIT_BUFFER_DEPTH entries) can never be overrun.
//
// Ports:
//   clk_noc         link clock, all logic on this clock
//   rst_n           asynchronous active-low reset
//   in_valid/in_ready, in_data, in_dest, in_is_tail
//                   local flit source (accepted on in_valid & in_ready)
//   send_out        one-cycle strobe per transferred flit
//   data_out, dest_out, is_tail_out
//                   link flit fields, held between launches
//   credit_in       one-cycle strobe, downstream freed one slot
//   credits_avail   current credit count
//   credit_overflow sticky flag: credit returned while already at full count
// -----------------------------------------------------------------------------
module noc_credit_tx #(
  parameter int FLIT_WIDTH        = 32,
  parameter int DEST_WIDTH        = 4,
  parameter int FLIT_BUFFER_DEPTH = 2,
  parameter int IN_FIFO_DEPTH     = 2,
  parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                    clk_noc,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FLIT_WIDTH-1:0]   in_data,
  input  logic [DEST_WIDTH-1:0]   in_dest,
  input  logic                    in_is_tail,
  output logic [FLIT_WIDTH-1:0]   data_out,
  output logic [DEST_WIDTH-1:0]   dest_out,
  output logic                    is_tail_out,
  output logic                    send_out,
  input  logic                    credit_in,
  output logic [CREDIT_WIDTH-1:0] credits_avail,
  output logic                    credit_overflow
);

  localparam int ENTRY_W = FLIT_WIDTH + DEST_WIDTH + 1;
  localparam int PTR_W   = $clog2(IN_FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  localparam logic [CNT_W-1:0]        FIFO_FULL  = CNT_W'(IN_FIFO_DEPTH);
  localparam logic [CNT_W-1:0]        FIFO_EMPTY = {CNT_W{1'b0}};
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_NONE = {CREDIT_WIDTH{1'b0}};

  // FIFO storage and bookkeeping
  logic [ENTRY_W-1:0]      fifo_mem_r [IN_FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        count_r;
  logic [CNT_W-1:0]        count_next_s;
  logic                    in_ready_r;

  // Launch / credit state
  logic                    push_s;
  logic                    launch_s;
  logic [CREDIT_WIDTH-1:0] credits_r;
  logic [CREDIT_WIDTH-1:0] credits_next_s;
  logic                    overflow_hit_s;
  logic                    overflow_r;

  // Registered link outputs
  logic                    send_r;
  logic [FLIT_WIDTH-1:0]   data_r;
  logic [DEST_WIDTH-1:0]   dest_r;
  logic                    tail_r;

  logic [ENTRY_W-1:0]      head_s;
  logic [ENTRY_W-1:0]      in_entry_s;

  assign in_ready        = in_ready_r;
  assign send_out        = send_r;
  assign data_out        = data_r;
  assign dest_out        = dest_r;
  assign is_tail_out     = tail_r;
  assign credits_avail   = credits_r;
  assign credit_overflow = overflow_r;

  assign in_entry_s = {in_data, in_dest, in_is_tail};
  assign head_s     = fifo_mem_r[rd_ptr_r];

  // Handshake, launch decision and next FIFO occupancy
  always_comb begin
    push_s       = in_valid & in_ready_r;
    // Launch needs a buffered flit and at least one downstream slot.
    launch_s     = (count_r != FIFO_EMPTY) && (credits_r != CREDIT_NONE);
    count_next_s = count_r;
    case ({push_s, launch_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Credit arithmetic: a launch and a returned credit in the same cycle cancel
  always_comb begin
    credits_next_s = credits_r;
    overflow_hit_s = 1'b0;
    case ({launch_s, credit_in})
      2'b10: credits_next_s = credits_r - CREDIT_WIDTH'(1);
      2'b01: begin
        // A credit with nothing outstanding means the downstream is out of
        // step with us; saturate and flag rather than wrap.
        if (credits_r == CREDIT_MAX) begin
          credits_next_s = credits_r;
          overflow_hit_s = 1'b1;
        end else begin
          credits_next_s = credits_r + CREDIT_WIDTH'(1);
          overflow_hit_s = 1'b0;
        end
      end
      default: credits_next_s = credits_r;
    endcase
  end

  // FIFO payload storage; contents are meaningless while count_r says empty
  always_ff @(posedge clk_noc) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= in_entry_s;
    end
  end

  // FIFO pointers, occupancy and registered in_ready
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= FIFO_EMPTY;
      in_ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (launch_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r    <= count_next_s;
      in_ready_r <= (count_next_s != FIFO_FULL);
    end
  end

  // Credit counter and sticky overflow flag
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      credits_r  <= CREDIT_MAX;
      overflow_r <= 1'b0;
    end else begin
      credits_r <= credits_next_s;
      if (overflow_hit_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Link output register: strobe for one cycle per launch, fields hold otherwise
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      send_r <= 1'b0;
      data_r <= {FLIT_WIDTH{1'b0}};
      dest_r <= {DEST_WIDTH{1'b0}};
      tail_r <= 1'b0;
    end else begin
      send_r <= launch_s;
      if (launch_s) begin
        data_r <= head_s[ENTRY_W-1 -: FLIT_WIDTH];
        dest_r <= head_s[DEST_WIDTH:1];
        tail_r <= head_s[0];
      end
    end
  end

endmodule

// File: tb/tb_noc_credit_tx.sv
// -----------------------------------------------------------------------------
// tb_noc_credit_tx
// Self-checking bench for noc_credit_tx. A queue-based reference model of the
// link (FIFO as a queue, credits as an integer) predicts every output each
// cycle; directed scenarios are followed by a randomized phase in which a
// simple downstream model returns credits after a random delay.
// -----------------------------------------------------------------------------
module tb_noc_credit_tx;

  localparam int FW  = 32;
  localparam int DW  = 4;
  localparam int FBD = 2;
  localparam int IFD = 2;
  localparam int CW  = $clog2(FBD + 1);

  typedef struct packed {
    logic [FW-1:0] d;
    logic [DW-1:0] t;
    logic          tail;
  } flit_t;

  logic          clk_noc = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] in_data;
  logic [DW-1:0] in_dest;
  logic          in_is_tail;
  logic [FW-1:0] data_out;
  logic [DW-1:0] dest_out;
  logic          is_tail_out;
  logic          send_out;
  logic          credit_in;
  logic [CW-1:0] credits_avail;
  logic          credit_overflow;

  // reference model state
  flit_t mq[$];
  int    m_cred;
  bit    m_ovf;
  bit    m_send;
  flit_t m_out;

  int total;
  int bad;
  int cyc;
  int rq[$];

  always #5 clk_noc = ~clk_noc;

  noc_credit_tx #(
    .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(FBD), .IN_FIFO_DEPTH(IFD)
  ) dut (
    .clk_noc(clk_noc), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dest(in_dest), .in_is_tail(in_is_tail),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
    .send_out(send_out), .credit_in(credit_in),
    .credits_avail(credits_avail), .credit_overflow(credit_overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cred = FBD;
    m_ovf  = 1'b0;
    m_send = 1'b0;
    m_out  = '0;
  endtask

  // One clock edge of the reference link, using the inputs currently driven.
  task automatic model_edge();
    bit acc;
    bit lau;
    if (!rst_n) begin
      model_reset();
    end else begin
      acc = in_valid && (mq.size() < IFD);
      lau = (mq.size() > 0) && (m_cred > 0);
      m_send = lau;
      if (lau) m_out = mq.pop_front();
      m_cred = m_cred - int'(lau) + int'(credit_in);
      if (m_cred > FBD) begin
        m_cred = FBD;
        m_ovf  = 1'b1;
      end
      if (acc) mq.push_back(flit_t'{in_data, in_dest, in_is_tail});
    end
  endtask

  task automatic compare_all();
    check("in_ready",  64'(in_ready),        64'(mq.size() < IFD));
    check("send_out",  64'(send_out),        64'(m_send));
    check("data_out",  64'(data_out),        64'(m_out.d));
    check("dest_out",  64'(dest_out),        64'(m_out.t));
    check("tail_out",  64'(is_tail_out),     64'(m_out.tail));
    check("credits",   64'(credits_avail),   64'(m_cred));
    check("overflow",  64'(credit_overflow), 64'(m_ovf));
  endtask

  // Drive inputs (we sit at a negedge), clock once, then compare at the negedge.
  task automatic cycle(input bit v, input logic [FW-1:0] d, input logic [DW-1:0] t,
                       input bit tl, input bit cin, output bit acc);
    in_valid   = v;
    in_data    = d;
    in_dest    = t;
    in_is_tail = tl;
    credit_in  = cin;
    acc = v && rst_n && (mq.size() < IFD);
    @(posedge clk_noc);
    model_edge();
    @(negedge clk_noc);
    compare_all();
    cyc++;
  endtask

  task automatic idle(input int n, input bit cin);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, cin, a);
  endtask

  // Hold a flit valid until accepted, with a bounded wait.
  task automatic push_flit(input logic [FW-1:0] d, input logic [DW-1:0] t, input bit tl);
    bit a;
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle(1'b1, d, t, tl, 1'b0, a);
      done = a;
    end
    if (!done) check("push_timeout", 64'(0), 64'(1));
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    idle(n, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    bit a;
    bit v;
    bit cin;
    total = 0; bad = 0; cyc = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_dest = '0;
    in_is_tail = 1'b0; credit_in = 1'b0;
    model_reset();
    @(negedge clk_noc);

    // Reset then idle
    do_reset(3);
    idle(4, 1'b0);
    check("idle_ready",   64'(in_ready),        64'(1));
    check("idle_credits", 64'(credits_avail),   64'(2));
    check("idle_send",    64'(send_out),        64'(0));
    check("idle_ovf",     64'(credit_overflow), 64'(0));

    // Latency and order; credits returned during each send cycle
    cycle(1'b1, 32'hA1, 4'h1, 1'b0, m_send, a);
    check("lat_no_send1", 64'(send_out), 64'(0));
    cycle(1'b1, 32'hA2, 4'h2, 1'b0, m_send, a);
    check("lat_send_a1", 64'(data_out), 64'hA1);
    cycle(1'b1, 32'hA3, 4'h3, 1'b1, m_send, a);
    check("lat_send_a2", 64'(data_out), 64'hA2);
    check("lat_tail_a2", 64'(is_tail_out), 64'(0));
    cycle(1'b0, '0, '0, 1'b0, m_send, a);
    check("lat_send_a3", 64'(data_out), 64'hA3);
    check("lat_tail_a3", 64'(is_tail_out), 64'(1));
    check("lat_sent3",   64'(send_out), 64'(1));
    cycle(1'b0, '0, '0, 1'b0, m_send, a);
    check("lat_done", 64'(send_out), 64'(0));
    idle(2, 1'b0);

    // Credit starvation
    push_flit(32'hB1, 4'h4, 1'b0);
    push_flit(32'hB2, 4'h5, 1'b0);
    push_flit(32'hB3, 4'h6, 1'b0);
    push_flit(32'hB4, 4'h7, 1'b1);
    idle(3, 1'b0);
    check("starve_credits", 64'(credits_avail), 64'(0));
    check("starve_ready",   64'(in_ready),      64'(0));
    check("starve_send",    64'(send_out),      64'(0));
    idle(1, 1'b1);
    idle(1, 1'b0);
    check("starve_relaunch", 64'(send_out),      64'(1));
    check("starve_b3",       64'(data_out),      64'hB3);
    check("starve_cred0",    64'(credits_avail), 64'(0));

    // Simultaneous launch and credit return
    push_flit(32'hC5, 4'h8, 1'b0);
    idle(1, 1'b1);
    check("sim_cred1", 64'(credits_avail), 64'(1));
    idle(1, 1'b1);
    check("sim_b4",       64'(data_out),      64'hB4);
    check("sim_cred_hold", 64'(credits_avail), 64'(1));
    idle(1, 1'b0);
    check("sim_c5",   64'(data_out), 64'hC5);
    check("sim_send", 64'(send_out), 64'(1));
    idle(2, 1'b0);

    // Overflow
    do_reset(2);
    idle(2, 1'b0);
    idle(1, 1'b1);
    check("ovf_credits", 64'(credits_avail),   64'(2));
    check("ovf_flag",    64'(credit_overflow), 64'(1));
    idle(10, 1'b0);
    check("ovf_sticky", 64'(credit_overflow), 64'(1));
    do_reset(2);
    check("ovf_cleared", 64'(credit_overflow), 64'(0));

    // Async reset mid-stream: two flits buffered, no credits
    push_flit(32'hD1, 4'h1, 1'b0);
    push_flit(32'hD2, 4'h2, 1'b0);
    push_flit(32'hD3, 4'h3, 1'b0);
    push_flit(32'hD4, 4'h4, 1'b1);
    idle(1, 1'b0);
    check("ar_pre_cred", 64'(credits_avail), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    check("ar_send",    64'(send_out),      64'(0));
    check("ar_data",    64'(data_out),      64'(0));
    check("ar_tail",    64'(is_tail_out),   64'(0));
    check("ar_credits", 64'(credits_avail), 64'(2));
    check("ar_ready",   64'(in_ready),      64'(1));
    model_reset();
    @(negedge clk_noc);
    idle(2, 1'b0);
    rst_n = 1'b1;
    idle(3, 1'b0);
    check("ar_post_ready", 64'(in_ready), 64'(1));
    check("ar_post_send",  64'(send_out), 64'(0));

    // Randomized traffic with a delayed-credit downstream
    do_reset(2);
    rq.delete();
    for (int i = 0; i < 1500; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      cin = 1'b0;
      if (rq.size() > 0 && rq[0] <= cyc) begin
        void'(rq.pop_front());
        cin = 1'b1;
      end
      cycle(v, FW'($urandom), DW'($urandom), 1'($urandom), cin, a);
      if (m_send) rq.push_back(cyc + int'($urandom_range(1, 4)));
    end
    check("rand_no_ovf", 64'(credit_overflow), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
